// File: rtl/if_fetch_queue_if.sv
// Inst-SRAM-like request/response channel between the fetch queue and the AXI bridge.
interface if_fetch_queue_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/if_fetch_queue.sv
// IF stage: keeps several inst-SRAM reads in flight, buffers returned instructions in a FIFO
// for ID, handles redirects by discarding stale responses, and reports misaligned PCs as ADEF.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              resetn,
  if_fetch_queue_if.master  inst_sram,
  input  logic              br_stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              wb_ex,
  input  logic [31:0]       ex_entry,
  input  logic              ertn_flush,
  input  logic [31:0]       ertn_entry,
  input  logic              ds_allowin,
  output logic              fs2ds_valid,
  output logic [64:0]       fs2ds_bus
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int FPTR_W = $clog2(IBUF_DEPTH);
  localparam int QPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SUM_W  = ((FCNT_W > CNT_W) ? FCNT_W : CNT_W) + 1;

  logic [31:0]       pc_r;
  logic              halt;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  discard_cnt;
  logic [FCNT_W-1:0] fifo_count;
  logic [FPTR_W-1:0] rd_ptr;
  logic [FPTR_W-1:0] wr_ptr;
  logic [QPTR_W-1:0] pq_rd;
  logic [QPTR_W-1:0] pq_wr;
  logic [64:0]       fifo_mem [IBUF_DEPTH];
  logic [31:0]       pc_q     [MAX_OUTSTANDING];

  logic              redir;
  logic [31:0]       redir_target;
  logic [31:0]       fetch_addr;
  logic              mis;
  logic              halt_eff;
  logic [FCNT_W-1:0] live_cnt;
  logic [CNT_W-1:0]  live_inflight;
  logic [SUM_W-1:0]  occ;
  logic              req;
  logic              accepted;
  logic              data_ok;
  logic              push_data;
  logic              push_adef;
  logic              push;
  logic              pop;
  logic [64:0]       push_entry;
  logic [FPTR_W-1:0] wr_idx;

  function automatic logic [FPTR_W-1:0] fptr_inc(input logic [FPTR_W-1:0] p);
    if (p == FPTR_W'(IBUF_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [QPTR_W-1:0] qptr_inc(input logic [QPTR_W-1:0] p);
    if (p == QPTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = 4'h0;
  assign inst_sram.wdata = 32'h0;
  assign inst_sram.req   = req;
  assign inst_sram.addr  = fetch_addr;
  assign data_ok         = inst_sram.data_ok;

  // Redirect selection and issue decision; space in the FIFO is reserved at issue time
  always_comb begin
    redir        = wb_ex | ertn_flush | br_taken;
    redir_target = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    fetch_addr   = redir ? redir_target : pc_r;
    mis          = (fetch_addr[1:0] != 2'b00);
    halt_eff     = halt & ~redir;
    live_cnt     = redir ? '0 : fifo_count;
    live_inflight = inflight - discard_cnt;
    occ          = SUM_W'(live_cnt) + SUM_W'(live_inflight);
    req          = resetn & ~br_stall & ~halt_eff & ~mis
                 & (inflight < CNT_W'(MAX_OUTSTANDING))
                 & (occ < SUM_W'(IBUF_DEPTH));
    accepted     = req & inst_sram.addr_ok;
    push_data    = data_ok & ~redir & (discard_cnt == '0);
    push_adef    = mis & ~halt_eff & (live_inflight == '0)
                 & (live_cnt < FCNT_W'(IBUF_DEPTH));
    push         = push_data | push_adef;
    pop          = fs2ds_valid & ds_allowin & ~redir;
    push_entry   = push_adef ? {32'h0, fetch_addr, 1'b1}
                             : {inst_sram.rdata, pc_q[pq_rd], 1'b0};
    wr_idx       = redir ? '0 : wr_ptr;
  end

  assign fs2ds_valid = (fifo_count != '0);
  assign fs2ds_bus   = fifo_mem[rd_ptr];

  // Control state: PC, halt, counters and queue pointers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r        <= RESET_PC;
      halt        <= 1'b0;
      inflight    <= '0;
      discard_cnt <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else begin
      pc_r     <= accepted ? fetch_addr + 32'd4 : fetch_addr;
      halt     <= push_adef ? 1'b1 : (redir ? 1'b0 : halt);
      inflight <= inflight + CNT_W'(accepted) - CNT_W'(data_ok);

      // Every request still outstanding before a redirect belongs to the old stream
      if (redir)
        discard_cnt <= inflight - CNT_W'(data_ok);
      else if (data_ok && (discard_cnt != '0))
        discard_cnt <= discard_cnt - 1'b1;

      if (accepted) pq_wr <= qptr_inc(pq_wr);
      if (data_ok)  pq_rd <= qptr_inc(pq_rd);

      if (redir) begin
        rd_ptr     <= '0;
        wr_ptr     <= push ? fptr_inc('0) : '0;
        fifo_count <= push ? FCNT_W'(1) : '0;
      end else begin
        if (push) wr_ptr <= fptr_inc(wr_ptr);
        if (pop)  rd_ptr <= fptr_inc(rd_ptr);
        fifo_count <= fifo_count + FCNT_W'(push) - FCNT_W'(pop);
      end
    end
  end

  // Storage for instruction entries and in-flight PCs
  always_ff @(posedge clk) begin
    if (push)     fifo_mem[wr_idx] <= push_entry;
    if (accepted) pc_q[pq_wr]      <= fetch_addr;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a one-cycle-latency in-order inst-SRAM model.
module tb_if_fetch_queue;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        aok = 1'b1;
  logic        ret_en = 1'b1;
  logic        br_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        wb_ex = 1'b0;
  logic [31:0] ex_entry = 32'h0;
  logic        ertn_flush = 1'b0;
  logic [31:0] ertn_entry = 32'h0;
  logic        ds_allowin = 1'b1;
  logic        fs2ds_valid;
  logic [64:0] fs2ds_bus;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_q [$];
  logic [31:0] acc_q [$];
  logic [64:0] out_q [$];

  if_fetch_queue_if sram_if();

  if_fetch_queue dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_sram   (sram_if),
    .br_stall    (br_stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .wb_ex       (wb_ex),
    .ex_entry    (ex_entry),
    .ertn_flush  (ertn_flush),
    .ertn_entry  (ertn_entry),
    .ds_allowin  (ds_allowin),
    .fs2ds_valid (fs2ds_valid),
    .fs2ds_bus   (fs2ds_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [64:0] out_at(input int k);
    if (out_q.size() > k) return out_q[k];
    return '1;
  endfunction

  function automatic logic [31:0] acc_at(input int k);
    if (acc_q.size() > k) return acc_q[k];
    return '1;
  endfunction

  assign sram_if.addr_ok = aok;

  // Memory model and capture of accepted addresses / delivered entries
  always @(posedge clk) begin
    if (!resetn) begin
      mem_q.delete();
      acc_q.delete();
      out_q.delete();
      sram_if.data_ok <= 1'b0;
      sram_if.rdata   <= 32'h0;
    end else begin
      if (sram_if.req && sram_if.addr_ok) begin
        mem_q.push_back(sram_if.addr);
        acc_q.push_back(sram_if.addr);
      end
      if (fs2ds_valid && ds_allowin) out_q.push_back(fs2ds_bus);
      if (ret_en && mem_q.size() > 0) begin
        sram_if.data_ok <= 1'b1;
        sram_if.rdata   <= inst_of(mem_q.pop_front());
      end else begin
        sram_if.data_ok <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    br_stall   = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    wb_ex      = 1'b0;
    ex_entry   = 32'h0;
    ertn_flush = 1'b0;
    ertn_entry = 32'h0;
  endtask

  task automatic do_reset(input logic allow, input logic ret);
    step();
    resetn = 1'b0;
    clr_in();
    aok        = 1'b1;
    ret_en     = ret;
    ds_allowin = allow;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    step();
    resetn = 1'b0;
    clr_in();
    aok = 1'b1; ret_en = 1'b1; ds_allowin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (sram_if.req !== 1'b0) begin fails++; $display("FAIL reset_req got %0b want 0", sram_if.req); end
    tests++;
    if (fs2ds_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", fs2ds_valid); end
    tests++;
    if (sram_if.addr !== RST_PC) begin fails++; $display("FAIL reset_addr got %h want %h", sram_if.addr, RST_PC); end
    step();
    resetn = 1'b1;
    @(negedge clk);
    tests++;
    if (sram_if.req !== 1'b1 || sram_if.addr !== RST_PC)
      begin fails++; $display("FAIL first_fetch got req=%0b addr=%h want req=1 addr=%h", sram_if.req, sram_if.addr, RST_PC); end
    step();
  endtask

  task automatic test_sequential();
    int first_acc;
    int first_vld;
    logic [31:0] pc;
    first_acc = -1;
    first_vld = -1;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sram_if.req && aok && first_acc < 0) first_acc = i;
      if (fs2ds_valid && first_vld < 0) first_vld = i;
      step();
    end
    tests++;
    if (first_acc != 0 || first_vld != 2)
      begin fails++; $display("FAIL seq_latency got acc=%0d vld=%0d want acc=0 vld=2", first_acc, first_vld); end
    for (int k = 0; k < 8; k++) begin
      pc = RST_PC + 32'(4 * k);
      tests++;
      if (out_at(k) !== {inst_of(pc), pc, 1'b0})
        begin fails++; $display("FAIL seq_entry%0d got %h want %h", k, out_at(k), {inst_of(pc), pc, 1'b0}); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pc;
    do_reset(1'b0, 1'b1);
    repeat (10) step();
    @(negedge clk);
    tests++;
    if (acc_q.size() != 4) begin fails++; $display("FAIL bp_accepts got %0d want 4", acc_q.size()); end
    tests++;
    if (sram_if.req !== 1'b0 || fs2ds_valid !== 1'b1 || out_q.size() != 0)
      begin fails++; $display("FAIL bp_full got req=%0b valid=%0b outs=%0d want req=0 valid=1 outs=0", sram_if.req, fs2ds_valid, out_q.size()); end
    step();
    ds_allowin = 1'b1;
    @(negedge clk);
    tests++;
    if (sram_if.req !== 1'b0) begin fails++; $display("FAIL bp_release_req got %0b want 0", sram_if.req); end
    step();
    @(negedge clk);
    tests++;
    if (sram_if.req !== 1'b1 || sram_if.addr !== RST_PC + 32'h10)
      begin fails++; $display("FAIL bp_resume got req=%0b addr=%h want req=1 addr=%h", sram_if.req, sram_if.addr, RST_PC + 32'h10); end
    repeat (8) step();
    for (int k = 0; k < 6; k++) begin
      pc = RST_PC + 32'(4 * k);
      tests++;
      if (out_at(k) !== {inst_of(pc), pc, 1'b0})
        begin fails++; $display("FAIL bp_entry%0d got %h want %h", k, out_at(k), {inst_of(pc), pc, 1'b0}); end
    end
  endtask

  task automatic test_branch_flush();
    logic busy;
    logic [31:0] tgt;
    tgt  = 32'h1C00_0100;
    busy = 1'b0;
    do_reset(1'b1, 1'b0);
    step();
    step();
    @(negedge clk);
    tests++;
    if (sram_if.req !== 1'b0 || acc_q.size() != 2)
      begin fails++; $display("FAIL br_two_inflight got req=%0b accepts=%0d want req=0 accepts=2", sram_if.req, acc_q.size()); end
    step();
    br_taken = 1'b1; br_target = tgt; ret_en = 1'b1;
    @(negedge clk);
    tests++;
    if (sram_if.addr !== tgt) begin fails++; $display("FAIL br_addr got %h want %h", sram_if.addr, tgt); end
    step();
    clr_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (fs2ds_valid !== 1'b0) busy = 1'b1;
      step();
    end
    tests++;
    if (busy) begin fails++; $display("FAIL br_flushed got valid=1 want valid=0"); end
    repeat (4) step();
    tests++;
    if (out_at(0) !== {inst_of(tgt), tgt, 1'b0})
      begin fails++; $display("FAIL br_first_out got %h want %h", out_at(0), {inst_of(tgt), tgt, 1'b0}); end
    tests++;
    if (acc_at(2) !== tgt) begin fails++; $display("FAIL br_accept got %h want %h", acc_at(2), tgt); end
  endtask

  task automatic test_priority();
    int idx;
    logic [31:0] ex_t;
    logic [31:0] er_t;
    ex_t = 32'h1C00_8000;
    er_t = 32'h1C00_4000;
    do_reset(1'b1, 1'b1);
    repeat (4) step();
    wb_ex = 1'b1; ex_entry = ex_t; br_taken = 1'b1; br_target = 32'h1C00_0100;
    @(negedge clk);
    tests++;
    if (sram_if.addr !== ex_t) begin fails++; $display("FAIL prio_ex_addr got %h want %h", sram_if.addr, ex_t); end
    step();
    clr_in();
    @(negedge clk);
    idx = out_q.size();
    repeat (5) step();
    tests++;
    if (out_at(idx) !== {inst_of(ex_t), ex_t, 1'b0})
      begin fails++; $display("FAIL prio_ex_out got %h want %h", out_at(idx), {inst_of(ex_t), ex_t, 1'b0}); end
    ertn_flush = 1'b1; ertn_entry = er_t; br_taken = 1'b1; br_target = 32'h1C00_0100;
    @(negedge clk);
    tests++;
    if (sram_if.addr !== er_t) begin fails++; $display("FAIL prio_ertn_addr got %h want %h", sram_if.addr, er_t); end
    step();
    clr_in();
    @(negedge clk);
    idx = out_q.size();
    repeat (5) step();
    tests++;
    if (out_at(idx) !== {inst_of(er_t), er_t, 1'b0})
      begin fails++; $display("FAIL prio_ertn_out got %h want %h", out_at(idx), {inst_of(er_t), er_t, 1'b0}); end
  endtask

  task automatic test_adef();
    int idx;
    logic seen_req;
    logic [31:0] bad;
    logic [31:0] ex_t;
    bad = 32'h1C00_0102;
    ex_t = 32'h1C00_8000;
    seen_req = 1'b0;
    do_reset(1'b1, 1'b1);
    repeat (3) step();
    br_taken = 1'b1; br_target = bad;
    @(negedge clk);
    tests++;
    if (sram_if.req !== 1'b0 || sram_if.addr !== bad)
      begin fails++; $display("FAIL adef_redir got req=%0b addr=%h want req=0 addr=%h", sram_if.req, sram_if.addr, bad); end
    step();
    clr_in();
    @(negedge clk);
    idx = out_q.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sram_if.req !== 1'b0) seen_req = 1'b1;
      step();
    end
    tests++;
    if (seen_req) begin fails++; $display("FAIL adef_halt got req=1 want req=0"); end
    tests++;
    if (out_q.size() != idx + 1) begin fails++; $display("FAIL adef_count got %0d want %0d", out_q.size() - idx, 1); end
    tests++;
    if (out_at(idx) !== {32'h0, bad, 1'b1})
      begin fails++; $display("FAIL adef_entry got %h want %h", out_at(idx), {32'h0, bad, 1'b1}); end
    wb_ex = 1'b1; ex_entry = ex_t;
    step();
    clr_in();
    repeat (5) step();
    tests++;
    if (out_at(idx + 1) !== {inst_of(ex_t), ex_t, 1'b0})
      begin fails++; $display("FAIL adef_recover got %h want %h", out_at(idx + 1), {inst_of(ex_t), ex_t, 1'b0}); end
  endtask

  task automatic test_br_stall();
    int n;
    logic seen_req;
    logic [31:0] tgt;
    tgt = 32'h1C00_0200;
    seen_req = 1'b0;
    do_reset(1'b1, 1'b1);
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      br_stall = 1'b1;
      br_taken = (i == 1);
      br_target = tgt;
      @(negedge clk);
      if (sram_if.req !== 1'b0) seen_req = 1'b1;
      step();
    end
    clr_in();
    tests++;
    if (seen_req) begin fails++; $display("FAIL stall_req got req=1 want req=0"); end
    @(negedge clk);
    n = acc_q.size();
    tests++;
    if (sram_if.req !== 1'b1 || sram_if.addr !== tgt)
      begin fails++; $display("FAIL stall_release got req=%0b addr=%h want req=1 addr=%h", sram_if.req, sram_if.addr, tgt); end
    repeat (4) step();
    tests++;
    if (acc_at(n) !== tgt) begin fails++; $display("FAIL stall_accept got %h want %h", acc_at(n), tgt); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b1);
    repeat (5) step();
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (fs2ds_valid !== 1'b0 || sram_if.req !== 1'b0 || sram_if.addr !== RST_PC)
      begin fails++; $display("FAIL mid_reset got valid=%0b req=%0b addr=%h want 0 0 %h", fs2ds_valid, sram_if.req, sram_if.addr, RST_PC); end
    step();
    resetn = 1'b1;
    ds_allowin = 1'b1;
    repeat (4) step();
    tests++;
    if (out_at(0) !== {inst_of(RST_PC), RST_PC, 1'b0})
      begin fails++; $display("FAIL mid_reset_out got %h want %h", out_at(0), {inst_of(RST_PC), RST_PC, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_flush();
    test_priority();
    test_adef();
    test_br_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
